instr_encoder: RTL
==================

# instr_encoder

- Streaming RISC-V RV32I instruction encoder: the write-side counterpart of the opcode/control decoder.
- Accepts decoded instruction fields over a valid/ready handshake and assembles the 32-bit instruction word.
- Writes each word into instruction memory at an auto-incrementing word address.
- Used by the test loader and boot path to populate imem; illegal field combinations are dropped and flagged.

## Interface
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, first word address written after reset or `start`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: write pointer := BASE_ADDR, clear `full` and `err`
- in_valid  in  1  input fields valid
- in_ready  out  1  input accepted when `in_valid && in_ready` at a clk edge
- in_kind  in  4  instruction class, encoding in package
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3, in_funct7  in  7  function fields
- in_imm  in  32  full signed byte offset or value (U-type: full 32-bit value)
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write when `imem_we && imem_ready`
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- wr_count  out  ADDR_W+1  words written since reset/start
- full  out  1  pointer exhausted
- err  out  1  sticky illegal-input flag
- err_code  out  2  first error: 01 imm range, 10 imm alignment, 11 bad kind

## Operation
- Formats:
  - OP: R-type.
  - OP_IMM, LOAD, JALR: I-type; JALR forces funct3 = 000.
  - STORE: S-type.
  - BRANCH: B-type.
  - LUI, AUIPC: U-type.
  - JAL: J-type.
  - All opcodes use standard RV32I values.
- OP_IMM with funct3 001/101 (shifts): bits[31:25] = funct7, bits[24:20] = imm[4:0]; imm must be 0..31.
- Range checks:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094], imm[0] = 0.
  - J: imm in [-2^20, 2^20-2], imm[0] = 0.
  - U: imm[11:0] = 0.
- Fields not used by a format are ignored.
- Illegal input:
  - Still consumed with a normal handshake; no write is issued.
  - `err` is set; `err_code` latches only if `err` was 0.
- FSM states:
  - IDLE: after reset. `start` → RUN.
  - RUN: accepts input. After the write to address 2^ADDR_W-1 completes → FULL.
  - FULL: `in_ready` = 0. `start` → RUN.
- Output stage: one register (`imem_we`, addr, data). `in_ready` = (state == RUN) && (!imem_we || imem_ready).
- Reset values: `in_ready`, `imem_we`, `full`, `err` = 0; `err_code`, `imem_wdata`, `wr_count` = 0; `imem_addr` = BASE_ADDR; state IDLE.

## Timing
- Latency: `imem_we` asserts the cycle after acceptance. `imem_addr`/`imem_wdata` are stable while `imem_we && !imem_ready`.
- Throughput: one word/cycle while `imem_ready` = 1.
- Pointer and `wr_count` increment at the edge where the write completes.
- `full` rises the cycle after the last write completes. No wrap-around: the pointer stays at the last address.
- `start` during a pending write: the pending write completes at its original address, then the pointer reloads. `start` has priority over a simultaneous acceptance: the acceptance is refused (`in_ready` = 0 that cycle).
- Async reset mid-write drops the pending write immediately.

## Structure
- Package `rv_isa_pkg`: opcode localparams (shared with the decoder), `in_kind` codes (0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP; others illegal), `err_code` values.
- Sub-module `instr_pack`: purely combinational field → word packing plus legality check. `instr_encoder` holds the FSM, output register and pointer.

## Test plan
- ADDI x1,x0,5 (kind 7, f3 000, imm 5) → `imem_wdata` 0x00500093 at BASE_ADDR, one cycle after acceptance.
- ADD x3,x1,x2 → 0x002081B3; SUB (funct7 0x20) → 0x402081B3; SW x2,4(x1) → 0x0020A223; LUI x5,0x12345000 → 0x123452B7.
- BEQ x1,x2,+8 → 0x00208463; JAL x1,-4 → 0xFFDFF0EF; BEQ imm 3 → no write, `err` = 1, `err_code` = 10.
- ADDI imm 2048 → `err_code` 01; then kind 15 → `err_code` stays 01; `start` clears `err`.
- Back-to-back stream with `imem_ready` low for 3 cycles → data and address held, `in_ready` = 0, no loss or duplication; `wr_count` matches the number of legal inputs.
- ADDR_W = 2: four writes → `full` = 1, `in_ready` = 0; `start` → writes resume at BASE_ADDR. `rst_n` pulsed mid-stall → all outputs at reset values immediately.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions: base opcodes, encoder input classes, error codes
// and a signed range helper used by the legality checks.
package rv_isa_pkg;

    // Standard RV32I major opcodes (bits [6:0] of the instruction word)
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction class presented on in_kind; codes 9..15 are illegal
    typedef enum logic [3:0] {
        KIND_LUI    = 4'd0,
        KIND_AUIPC  = 4'd1,
        KIND_JAL    = 4'd2,
        KIND_JALR   = 4'd3,
        KIND_BRANCH = 4'd4,
        KIND_LOAD   = 4'd5,
        KIND_STORE  = 4'd6,
        KIND_OP_IMM = 4'd7,
        KIND_OP     = 4'd8
    } kind_e;

    // Reason an input was dropped; a range violation is reported ahead of
    // an alignment violation when both apply
    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_KIND  = 2'b11
    } err_e;

    // True when v, read as a signed 32-bit value, lies in [lo, hi]
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        int sv;
        sv = $signed(v);
        return (sv >= lo) && (sv <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packing for RV32I plus the legality check
// that decides whether the packed word may be written.
module instr_pack
    import rv_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal,
    output logic [1:0]  code
);

    logic is_shift;

    // Shift-immediates reuse the I-type slot: funct7 on top, shamt below
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Assemble the word for the requested format and classify any violation
    always_comb begin
        word = 32'h0;
        code = ERR_NONE;
        case (kind)
            KIND_LUI: begin
                word = {imm[31:12], rd, OPC_LUI};
                if (imm[11:0] != 12'h0) code = ERR_ALIGN;
            end
            KIND_AUIPC: begin
                word = {imm[31:12], rd, OPC_AUIPC};
                if (imm[11:0] != 12'h0) code = ERR_ALIGN;
            end
            KIND_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                if (!in_range(imm, -(1 << 20), (1 << 20) - 2)) code = ERR_RANGE;
                else if (imm[0]) code = ERR_ALIGN;
            end
            KIND_JALR: begin
                word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
            end
            KIND_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                if (!in_range(imm, -4096, 4094)) code = ERR_RANGE;
                else if (imm[0]) code = ERR_ALIGN;
            end
            KIND_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
                if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
            end
            KIND_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
                if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
            end
            KIND_OP_IMM: begin
                if (is_shift) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                    if (!in_range(imm, 0, 31)) code = ERR_RANGE;
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
                    if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
                end
            end
            KIND_OP: begin
                word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
            end
            default: begin
                code = ERR_KIND;
            end
        endcase
    end

    assign legal = (code == ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts decoded fields, packs them into words and
// writes them to instruction memory at an auto-incrementing word address.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e      state;
    state_e      state_next;
    logic [31:0] pack_word;
    logic        pack_legal;
    logic [1:0]  pack_code;
    logic        write_done;
    logic        accept;
    logic        last_hold;
    logic        reload_pending;

    instr_pack u_pack (
        .kind   (in_kind),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (pack_word),
        .legal  (pack_legal),
        .code   (pack_code)
    );

    assign write_done = imem_we && imem_ready;
    assign accept     = in_valid && in_ready;
    // While the final address is in flight nothing else may be accepted,
    // otherwise the follow-on word would land on the same (saturated) address
    assign last_hold  = imem_we && (imem_addr == LAST) && !reload_pending;
    assign full       = (state == ST_FULL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake: start wins over a same-cycle acceptance
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                in_ready = !start && (!imem_we || imem_ready) && !last_hold;
                if (!start && !reload_pending && write_done && (imem_addr == LAST))
                    state_next = ST_FULL;
            end
            ST_FULL: begin
                if (start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output stage register; holds address and data while memory stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_wdata <= 32'h0;
        end else if (write_done || !imem_we) begin
            imem_we <= accept && pack_legal;
            if (accept && pack_legal) imem_wdata <= pack_word;
        end
    end

    // Write pointer and count; a start that arrives while a write is pending
    // is deferred until that write retires at its original address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr      <= BASE;
            wr_count       <= '0;
            reload_pending <= 1'b0;
        end else if (write_done) begin
            reload_pending <= 1'b0;
            if (start || reload_pending) begin
                imem_addr <= BASE;
                wr_count  <= '0;
            end else begin
                wr_count <= wr_count + 1'b1;
                if (imem_addr != LAST) imem_addr <= imem_addr + 1'b1;
            end
        end else if (start) begin
            if (imem_we) begin
                reload_pending <= 1'b1;
            end else begin
                imem_addr <= BASE;
                wr_count  <= '0;
            end
        end
    end

    // Sticky error flag; the code records only the first offence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (start) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (accept && !pack_legal) begin
            err <= 1'b1;
            if (!err) err_code <= pack_code;
        end
    end

endmodule
